// File: rtl/uart_rx_fifo.sv
// Receive byte FIFO between the loader's DATA/VALID strobe and the FROM_HOST MMIO read word.
// Optional high-water-mark output and RDATA field: define UART_RX_FIFO_HWM_EN.
module uart_rx_fifo #(
  parameter int unsigned DEPTH_LOG = 4
) (
  input  logic                 CLK,
  input  logic                 RST_X,
  input  logic [7:0]           RX_DATA,
  input  logic                 RX_VALID,
  input  logic                 POP,
  input  logic                 CLR,
  output logic [31:0]          RDATA,
  output logic                 EMPTY,
  output logic                 FULL,
  output logic [DEPTH_LOG:0]   COUNT,
  output logic                 OVERFLOW
`ifdef UART_RX_FIFO_HWM_EN
  ,output logic [DEPTH_LOG:0]  HWM
`endif
);

  localparam int unsigned DEPTH = 2 ** DEPTH_LOG;
  localparam int unsigned CW    = DEPTH_LOG + 1;

  logic [7:0]           mem [DEPTH];
  logic [DEPTH_LOG-1:0] rd_ptr, rd_ptr_nxt;
  logic [DEPTH_LOG-1:0] wr_ptr, wr_ptr_nxt;
  logic [CW-1:0]        count, count_nxt;
  logic                 empty, empty_nxt;
  logic                 full, full_nxt;
  logic                 ovf, ovf_nxt;
  logic [7:0]           head, head_nxt;
  logic                 do_push, do_pop;

  // Next-state: CLR wins; a pop frees a slot for a same-cycle push when full.
  always_comb begin
    do_pop     = POP && !empty;
    do_push    = RX_VALID && (!full || do_pop);
    rd_ptr_nxt = rd_ptr;
    wr_ptr_nxt = wr_ptr;
    count_nxt  = count;
    empty_nxt  = empty;
    full_nxt   = full;
    ovf_nxt    = ovf;
    head_nxt   = head;
    if (CLR) begin
      rd_ptr_nxt = '0;
      wr_ptr_nxt = '0;
      count_nxt  = '0;
      empty_nxt  = 1'b1;
      full_nxt   = 1'b0;
      ovf_nxt    = 1'b0;
      head_nxt   = 8'h00;
    end else begin
      if (do_pop)  rd_ptr_nxt = rd_ptr + DEPTH_LOG'(1);
      if (do_push) wr_ptr_nxt = wr_ptr + DEPTH_LOG'(1);
      count_nxt = count + CW'(do_push) - CW'(do_pop);
      empty_nxt = (count_nxt == '0);
      full_nxt  = (count_nxt == CW'(DEPTH));
      if (RX_VALID && !do_push) ovf_nxt = 1'b1;
      // Head is pre-fetched so RDATA comes straight from a flop; the incoming
      // byte bypasses storage when it lands in the head slot.
      if (empty_nxt)                           head_nxt = 8'h00;
      else if (do_push && wr_ptr == rd_ptr_nxt) head_nxt = RX_DATA;
      else                                     head_nxt = mem[rd_ptr_nxt];
    end
  end

  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
      ovf    <= 1'b0;
      head   <= 8'h00;
    end else begin
      rd_ptr <= rd_ptr_nxt;
      wr_ptr <= wr_ptr_nxt;
      count  <= count_nxt;
      empty  <= empty_nxt;
      full   <= full_nxt;
      ovf    <= ovf_nxt;
      head   <= head_nxt;
    end
  end

  // Storage is intentionally not reset.
  always_ff @(posedge CLK) begin
    if (do_push && !CLR) mem[wr_ptr] <= RX_DATA;
  end

  assign EMPTY    = empty;
  assign FULL     = full;
  assign COUNT    = count;
  assign OVERFLOW = ovf;

`ifdef UART_RX_FIFO_HWM_EN
  logic [CW-1:0] hwm;

  // Tracks peak occupancy one cycle behind COUNT.
  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X)           hwm <= '0;
    else if (CLR)         hwm <= '0;
    else if (count > hwm) hwm <= count;
  end

  assign HWM   = hwm;
  assign RDATA = {empty, {(23 - CW){1'b0}}, hwm, head};
`else
  assign RDATA = {empty, 23'h0, head};
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed steps plus random traffic against a queue model.
module tb_uart_rx_fifo;

  localparam int unsigned DL    = 4;
  localparam int unsigned DEPTH = 2 ** DL;

  logic          CLK = 1'b0;
  logic          RST_X = 1'b0;
  logic [7:0]    RX_DATA = 8'h00;
  logic          RX_VALID = 1'b0;
  logic          POP = 1'b0;
  logic          CLR = 1'b0;
  logic [31:0]   RDATA;
  logic          EMPTY;
  logic          FULL;
  logic [DL:0]   COUNT;
  logic          OVERFLOW;
`ifdef UART_RX_FIFO_HWM_EN
  logic [DL:0]   HWM;
`endif

  uart_rx_fifo #(.DEPTH_LOG(DL)) dut (
    .CLK(CLK), .RST_X(RST_X), .RX_DATA(RX_DATA), .RX_VALID(RX_VALID),
    .POP(POP), .CLR(CLR), .RDATA(RDATA), .EMPTY(EMPTY), .FULL(FULL),
    .COUNT(COUNT), .OVERFLOW(OVERFLOW)
`ifdef UART_RX_FIFO_HWM_EN
    , .HWM(HWM)
`endif
  );

  always #5 CLK = ~CLK;

  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] q[$];
  logic       ovf_m = 1'b0;
  int         hwm_m = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_rdata();
    logic [31:0] r;
    r = 32'h0;
    r[31] = (q.size() == 0);
    if (q.size() != 0) r[7:0] = q[0];
`ifdef UART_RX_FIFO_HWM_EN
    r[8 +: DL + 1] = (DL + 1)'(hwm_m);
`endif
    return r;
  endfunction

  task automatic check_all();
    chk("rdata", RDATA, exp_rdata());
    chk("empty", 32'(EMPTY), 32'(q.size() == 0));
    chk("full", 32'(FULL), 32'(q.size() == DEPTH));
    chk("count", 32'(COUNT), 32'(q.size()));
    chk("overflow", 32'(OVERFLOW), 32'(ovf_m));
`ifdef UART_RX_FIFO_HWM_EN
    chk("hwm", 32'(HWM), 32'(hwm_m));
`endif
  endtask

  // Reference: a byte queue; HWM trails occupancy by one edge.
  task automatic model(input logic v, input logic [7:0] d, input logic p, input logic c);
    int prev;
    prev = q.size();
    if (c) begin
      q.delete();
      ovf_m = 1'b0;
      hwm_m = 0;
    end else begin
      if (p && q.size() > 0) void'(q.pop_front());
      if (v) begin
        if (q.size() < DEPTH) q.push_back(d);
        else ovf_m = 1'b1;
      end
      if (prev > hwm_m) hwm_m = prev;
    end
  endtask

  task automatic step(input logic v, input logic [7:0] d, input logic p, input logic c);
    RX_VALID = v; RX_DATA = d; POP = p; CLR = c;
    @(posedge CLK);
    model(v, d, p, c);
    #1;
    check_all();
    RX_VALID = 1'b0; POP = 1'b0; CLR = 1'b0;
  endtask

  initial begin
    int pushed;
    int guard;
    logic v, p;

    // Reset and idle
    repeat (3) @(posedge CLK);
    #1;
    check_all();
    chk("reset_rdata", RDATA, 32'h8000_0000);
    @(negedge CLK);
    RST_X = 1'b1;
    step(0, 8'h00, 0, 0);
    chk("idle_rdata", RDATA, 32'h8000_0000);

    // Three bytes on non-consecutive cycles, then drain
    step(1, 8'h41, 0, 0); step(0, 8'h00, 0, 0);
    step(1, 8'h42, 0, 0); step(0, 8'h00, 0, 0);
    step(1, 8'h43, 0, 0); step(0, 8'h00, 0, 0);
    chk("abc_count3", 32'(COUNT), 32'd3);
    chk("abc_rdata41", RDATA & 32'h8000_00FF, 32'h0000_0041);
    step(0, 8'h00, 1, 0);
    chk("abc_rdata42", RDATA & 32'h8000_00FF, 32'h0000_0042);
    chk("abc_count2", 32'(COUNT), 32'd2);
    step(0, 8'h00, 1, 0);
    chk("abc_rdata43", RDATA & 32'h8000_00FF, 32'h0000_0043);
    step(0, 8'h00, 1, 0);
    chk("abc_empty", RDATA & 32'h8000_00FF, 32'h8000_0000);
    chk("abc_count0", 32'(COUNT), 32'd0);
    step(0, 8'h00, 1, 0);

    // Overfill by one byte
    step(0, 8'h00, 0, 1);
    for (int i = 0; i <= 16; i++) step(1, 8'(i), 0, 0);
    chk("ovf_full", 32'(FULL), 32'd1);
    chk("ovf_count", 32'(COUNT), 32'd16);
    chk("ovf_flag", 32'(OVERFLOW), 32'd1);
    for (int i = 0; i < 16; i++) begin
      chk("ovf_drain", 32'(RDATA[7:0]), 32'(i));
      step(0, 8'h00, 1, 0);
    end
    chk("ovf_drained", 32'(RDATA[31]), 32'd1);
    chk("ovf_sticky", 32'(OVERFLOW), 32'd1);

    // Full with simultaneous push and pop
    step(0, 8'h00, 0, 1);
    for (int i = 0; i < 16; i++) step(1, 8'($urandom), 0, 0);
    step(1, 8'hAA, 1, 0);
    chk("fpp_count", 32'(COUNT), 32'd16);
    chk("fpp_ovf", 32'(OVERFLOW), 32'd0);
    for (int i = 0; i < 15; i++) step(0, 8'h00, 1, 0);
    chk("fpp_last", RDATA & 32'h8000_00FF, 32'h0000_00AA);
    step(0, 8'h00, 1, 0);

    // CLR beats coincident push and pop
    for (int i = 0; i < 5; i++) step(1, 8'($urandom), 0, 0);
    step(1, 8'h5A, 1, 1);
    chk("clr_count", 32'(COUNT), 32'd0);
    chk("clr_empty", 32'(EMPTY), 32'd1);
    chk("clr_ovf", 32'(OVERFLOW), 32'd0);
`ifdef UART_RX_FIFO_HWM_EN
    chk("clr_hwm", 32'(HWM), 32'd0);
`endif

    // Wrap-around with occupancy held at 3 or less
    step(1, 8'($urandom), 0, 0);
    step(1, 8'($urandom), 0, 0);
    step(1, 8'($urandom), 0, 0);
    pushed = 3;
    guard = 0;
    while ((pushed < 40 || q.size() > 0) && guard < 2000) begin
      v = (pushed < 40) && (q.size() < 3) && ($urandom_range(0, 1) == 1);
      p = (q.size() > 0) && ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 3) == 0) begin v = 1'b0; p = 1'b0; end
      step(v, 8'($urandom), p, 0);
      if (v) pushed++;
      guard++;
    end
    chk("wrap_pushed", 32'(pushed), 32'd40);
    chk("wrap_count", 32'(COUNT), 32'd0);
    step(0, 8'h00, 0, 0);
`ifdef UART_RX_FIFO_HWM_EN
    chk("wrap_hwm", 32'(HWM), 32'd3);
`endif

    // Random soak including overflow and occasional CLR
    for (int i = 0; i < 400; i++)
      step(($urandom_range(0, 2) != 0), 8'($urandom), ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 60) == 0));

    // Asynchronous reset mid-operation
    for (int i = 0; i < 6; i++) step(1, 8'($urandom), 0, 0);
    RST_X = 1'b0;
    #1;
    q.delete(); ovf_m = 1'b0; hwm_m = 0;
    check_all();
    chk("async_rst_rdata", RDATA, 32'h8000_0000);
    @(negedge CLK);
    RST_X = 1'b1;
    step(1, 8'h7E, 0, 0);
    chk("post_rst_rdata", RDATA & 32'h8000_00FF, 32'h0000_007E);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Receive-side byte buffer between the program loader's received-byte output (DATA/VALID) and the MMIO FROM_HOST register. It replaces the single-byte hold register and its unread flag with a DEPTH-entry FIFO, so bytes arriving faster than software polls are not lost. RDATA is formatted as the FROM_HOST read word, so the MMIO read mux uses it directly. A software write to FROM_HOST drives POP.

Parameters:
DEPTH_LOG, 4, log2 of FIFO depth (DEPTH = 2**DEPTH_LOG = 16 entries); legal range 1..8

Ports:
CLK  input  1  system clock; single clock domain
RST_X  input  1  asynchronous active-low reset
RX_DATA  input  8  received byte from loader
RX_VALID  input  1  1-cycle strobe; RX_DATA is valid this cycle
POP  input  1  discard head entry (MMIO write to FROM_HOST)
CLR  input  1  synchronous flush: empties FIFO, clears OVERFLOW
RDATA  output  32  {EMPTY, 23'h0, head byte}; head byte is 8'h00 when empty
EMPTY  output  1  no entries
FULL  output  1  COUNT == DEPTH
COUNT  output  DEPTH_LOG+1  entries held, 0..DEPTH
OVERFLOW  output  1  sticky; a byte was dropped because the FIFO was full

Behaviour:
- Reset (RST_X low, asynchronous): rd_ptr=0, wr_ptr=0, COUNT=0, EMPTY=1, FULL=0, OVERFLOW=0, RDATA=32'h8000_0000. Storage array is not reset.
- Storage: DEPTH x 8 register array. rd_ptr and wr_ptr are DEPTH_LOG bits wide and wrap naturally from DEPTH-1 to 0. COUNT is held separately and is the width-extended difference.
- All outputs derive from registers only: no combinational path from RX_VALID or POP to any output.
- Push: RX_VALID && !FULL -> mem[wr_ptr] <= RX_DATA, wr_ptr+1, COUNT+1. The byte appears in RDATA the next cycle if the FIFO was empty (1-cycle latency).
- Pop: POP && !EMPTY -> rd_ptr+1, COUNT-1. The new head appears in RDATA the next cycle. POP while EMPTY is ignored: no pointer change, no error.
- Push and pop in the same cycle, non-empty: both occur and COUNT is unchanged.
- Push and pop in the same cycle when FULL: pop frees a slot and the push is accepted. The byte is not dropped and OVERFLOW is not set.
- Push and pop in the same cycle when EMPTY: the push is accepted and the pop is ignored. COUNT becomes 1.
- Drop: RX_VALID && FULL && !POP -> byte discarded, OVERFLOW <= 1. OVERFLOW stays set until CLR or reset.
- CLR has priority over push and pop in the same cycle: pointers=0, COUNT=0, OVERFLOW=0, and a coincident RX_VALID byte is discarded.
- EMPTY and FULL are registered alongside COUNT; they are never derived from pointer equality alone.
- Reset asserted mid-operation: all contents are lost immediately and the outputs return to their reset values asynchronously.
- RDATA[31] is 1 when no byte is available. This preserves the existing FROM_HOST polling convention, where software loops while bit 31 is set.

Optional Feature:
UART_RX_FIFO_HWM_EN
- Defined: adds output HWM [DEPTH_LOG+1]. HWM is the maximum COUNT seen since reset or CLR and updates on the cycle after COUNT rises. Reset value is 0; CLR sets it to 0. HWM is also readable as RDATA[8+:DEPTH_LOG+1] in place of the zero field, so RDATA[30:8+DEPTH_LOG+1] stays 0.
- Undefined: no HWM port, no HWM register, and RDATA[30:8] is all zero.

Test Plan:
- Reset, then idle -> RDATA=32'h8000_0000, EMPTY=1, COUNT=0, OVERFLOW=0.
- Push 8'h41, 8'h42, 8'h43 on non-consecutive cycles, then POP three times -> RDATA sequence: 32'h0000_0041, 32'h0000_0042, 32'h0000_0043, 32'h8000_0000. COUNT steps 3,2,1,0.
- Push 17 bytes 8'h00..8'h10 with DEPTH_LOG=4 and no pops -> FULL=1, COUNT=16, OVERFLOW=1. Draining yields 8'h00..8'h0F; 8'h10 is absent.
- FULL with RX_VALID=1 (byte 8'hAA) and POP=1 in the same cycle -> COUNT stays 16, OVERFLOW=0, and 8'hAA is the last byte drained.
- Fill 5 bytes, assert CLR together with RX_VALID and POP -> next cycle COUNT=0, EMPTY=1, OVERFLOW=0; HWM=0 when UART_RX_FIFO_HWM_EN is defined.
- Wrap-around: 40 push/pop pairs interleaved with random gaps, occupancy never above 3 -> data order preserved, pointers wrap with no corruption. With UART_RX_FIFO_HWM_EN defined, HWM=3.
